// File: rtl/enemy_array_control.sv
// Bouncing-enemy controller: steps every enemy on a rate tick, checks for a
// collision with the player, then streams one redraw record per enabled enemy.
module enemy_array_control #(
    parameter int N_ENEMY     = 4,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int PLAYER_SIZE = 3,
    parameter int RATE_DIV    = 1000000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load_level,
    input  logic                   play,
    input  logic [8*N_ENEMY-1:0]   cfg_x,
    input  logic [7*N_ENEMY-1:0]   cfg_y,
    input  logic [3*N_ENEMY-1:0]   cfg_size,
    input  logic [3*N_ENEMY-1:0]   cfg_dx,
    input  logic [3*N_ENEMY-1:0]   cfg_dy,
    input  logic [N_ENEMY-1:0]     cfg_left,
    input  logic [N_ENEMY-1:0]     cfg_up,
    input  logic [N_ENEMY-1:0]     cfg_en,
    input  logic [7:0]             player_x,
    input  logic [6:0]             player_y,
    output logic [8*N_ENEMY-1:0]   enemy_x,
    output logic [7*N_ENEMY-1:0]   enemy_y,
    output logic                   player_hit,
    output logic [2:0]             hit_id,
    output logic                   draw_valid,
    input  logic                   draw_ready,
    output logic [2:0]             draw_id,
    output logic [7:0]             draw_x,
    output logic [6:0]             draw_y,
    output logic [2:0]             draw_size,
    output logic                   step_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_DRAW   = 2'd2;
    localparam int CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_DIV - 1);
    localparam logic [2:0] LAST_IDX = 3'(N_ENEMY - 1);

    // One axis step; bit 10 flags a wall bounce, bits 9:0 hold the new coordinate.
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic [9:0] step,
                                              input logic [9:0] size, input logic [9:0] limit,
                                              input logic neg);
        logic [10:0] r;
        if (neg) begin
            r = (pos <= step) ? {1'b1, 10'd0} : {1'b0, pos - step};
        end else begin
            r = (pos + step + size >= limit) ? {1'b1, limit - size} : {1'b0, pos + step};
        end
        return r;
    endfunction

    // Lowest enabled index >= from; bit 3 says whether one exists.
    function automatic logic [3:0] first_enabled(input logic [7:0] en, input logic [3:0] from);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            r = (en[i] && (4'(i) >= from)) ? {1'b1, 3'(i)} : r;
        end
        return r;
    endfunction

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [8*N_ENEMY-1:0] ex_q, ex_d;
    logic [7*N_ENEMY-1:0] ey_q, ey_d;
    logic [7:0]           left_q, left_d, up_q, up_d;
    logic                 hit_q, hit_d;
    logic [2:0]           hit_id_q, hit_id_d;
    logic                 dv_q, dv_d;
    logic [2:0]           did_q, did_d;
    logic [7:0]           dx_q, dx_d;
    logic [6:0]           dy_q, dy_d;
    logic [2:0]           dsize_q, dsize_d;
    logic                 sd_q, sd_d;

    logic [7:0]  en_s;
    logic [2:0]  size_s;
    logic [10:0] step_x_s, step_y_s;
    logic        hit_s;
    logic [3:0]  sel_s;
    logic        load_rec_s;

    assign en_s     = 8'(cfg_en);
    assign size_s   = cfg_size[3*idx_q +: 3];
    assign step_x_s = axis_step({2'b00, ex_q[8*idx_q +: 8]}, {7'b0, cfg_dx[3*idx_q +: 3]},
                                {7'b0, size_s}, 10'(SCREEN_W), left_q[idx_q]);
    assign step_y_s = axis_step({3'b000, ey_q[7*idx_q +: 7]}, {7'b0, cfg_dy[3*idx_q +: 3]},
                                {7'b0, size_s}, 10'(SCREEN_H), up_q[idx_q]);
    // Overlap test on the freshly computed position of the enemy being updated.
    assign hit_s = ({2'b00, player_x} <= step_x_s[9:0] + {7'b0, size_s} - 10'd1) &&
                   (step_x_s[9:0] <= {2'b00, player_x} + 10'(PLAYER_SIZE) - 10'd1) &&
                   ({3'b000, player_y} <= step_y_s[9:0] + {7'b0, size_s} - 10'd1) &&
                   (step_y_s[9:0] <= {3'b000, player_y} + 10'(PLAYER_SIZE) - 10'd1);

    // Next-state logic for the rate counter, enemy update pass and draw stream.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ex_d       = ex_q;
        ey_d       = ey_q;
        left_d     = left_q;
        up_d       = up_q;
        hit_d      = hit_q;
        hit_id_d   = hit_id_q;
        dv_d       = dv_q;
        did_d      = did_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        dsize_d    = dsize_q;
        sd_d       = 1'b0;
        sel_s      = 4'd0;
        load_rec_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (play) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = {CNT_W{1'b0}};
                        idx_d   = 3'd0;
                        state_d = S_UPDATE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_UPDATE: begin
                if (en_s[idx_q]) begin
                    ex_d[8*idx_q +: 8] = step_x_s[7:0];
                    ey_d[7*idx_q +: 7] = step_y_s[6:0];
                    left_d[idx_q]      = left_q[idx_q] ^ step_x_s[10];
                    up_d[idx_q]        = up_q[idx_q] ^ step_y_s[10];
                    if (hit_s && !hit_q) begin
                        hit_d    = 1'b1;
                        hit_id_d = idx_q;
                    end else begin
                        hit_d = hit_q;
                    end
                end else begin
                    ex_d = ex_q;
                end
                if (idx_q == LAST_IDX) begin
                    sel_s = first_enabled(en_s, 4'd0);
                    if (sel_s[3]) begin
                        load_rec_s = 1'b1;
                        state_d    = S_DRAW;
                    end else begin
                        sd_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_DRAW: begin
                if (dv_q && draw_ready) begin
                    sel_s = first_enabled(en_s, {1'b0, did_q} + 4'd1);
                    if (sel_s[3]) begin
                        load_rec_s = 1'b1;
                    end else begin
                        dv_d    = 1'b0;
                        sd_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (!dv_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAW;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // ex_d/ey_d already include the enemy updated this cycle.
        if (load_rec_s) begin
            dv_d    = 1'b1;
            did_d   = sel_s[2:0];
            dx_d    = ex_d[8*sel_s[2:0] +: 8];
            dy_d    = ey_d[7*sel_s[2:0] +: 7];
            dsize_d = cfg_size[3*sel_s[2:0] +: 3];
        end else begin
            did_d = did_q;
        end
    end

    // State registers; reset and level reload both restore the configuration.
    always_ff @(posedge clk) begin
        if (!resetn || load_level) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            idx_q    <= 3'd0;
            ex_q     <= cfg_x;
            ey_q     <= cfg_y;
            left_q   <= 8'(cfg_left);
            up_q     <= 8'(cfg_up);
            hit_q    <= 1'b0;
            hit_id_q <= 3'd0;
            dv_q     <= 1'b0;
            did_q    <= 3'd0;
            dx_q     <= 8'd0;
            dy_q     <= 7'd0;
            dsize_q  <= 3'd0;
            sd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ex_q     <= ex_d;
            ey_q     <= ey_d;
            left_q   <= left_d;
            up_q     <= up_d;
            hit_q    <= hit_d;
            hit_id_q <= hit_id_d;
            dv_q     <= dv_d;
            did_q    <= did_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            dsize_q  <= dsize_d;
            sd_q     <= sd_d;
        end
    end

    assign enemy_x    = ex_q;
    assign enemy_y    = ey_q;
    assign player_hit = hit_q;
    assign hit_id     = hit_id_q;
    assign draw_valid = dv_q;
    assign draw_id    = did_q;
    assign draw_x     = dx_q;
    assign draw_y     = dy_q;
    assign draw_size  = dsize_q;
    assign step_done  = sd_q;

endmodule

// File: doc/enemy_array_control.md
ENEMY_ARRAY_CONTROL -- requirements
Module: enemy_array_control

Interface
REQ-001 Parameter N_ENEMY, default 4: number of independent enemies, 1..8.
REQ-002 Parameter SCREEN_W, default 160: playfield width in pixels.
REQ-003 Parameter SCREEN_H, default 120: playfield height in pixels.
REQ-004 Parameter PLAYER_SIZE, default 3: player square edge in pixels.
REQ-005 Parameter RATE_DIV, default 1000000: clk cycles between motion steps.
REQ-006 Port list SHALL be as follows; reset resetn, synchronous, active-low; clock clk:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- load_level  in  1  reload all enemies from configuration
- play  in  1  motion enable
- cfg_x  in  8*N_ENEMY  start X per enemy (enemy i at bits [8i+7:8i])
- cfg_y  in  7*N_ENEMY  start Y per enemy
- cfg_size  in  3*N_ENEMY  square edge per enemy, 1..7
- cfg_dx  in  3*N_ENEMY  X step per motion step
- cfg_dy  in  3*N_ENEMY  Y step per motion step
- cfg_left  in  N_ENEMY  initial direction, 1 = leftwards
- cfg_up  in  N_ENEMY  initial direction, 1 = upwards
- cfg_en  in  N_ENEMY  enemy active mask
- player_x  in  8  player top-left X
- player_y  in  7  player top-left Y
- enemy_x  out  8*N_ENEMY  current top-left X per enemy
- enemy_y  out  7*N_ENEMY  current top-left Y per enemy
- player_hit  out  1  sticky collision flag
- hit_id  out  3  index of first colliding enemy
- draw_valid  out  1  redraw record valid
- draw_ready  in  1  renderer accepts record
- draw_id  out  3  enemy index of record
- draw_x  out  8  X of record
- draw_y  out  7  Y of record
- draw_size  out  3  edge of record
- step_done  out  1  one-cycle pulse when a full step and its draw phase finish

Function
REQ-007 FSM states SHALL be IDLE, UPDATE, DRAW.
REQ-008 In IDLE with play=1, counter SHALL increment each cycle; at counter==RATE_DIV-1 it SHALL clear and the FSM SHALL enter UPDATE with index 0; with play=0 the counter SHALL hold.
REQ-009 UPDATE SHALL process one enemy per cycle, index 0..N_ENEMY-1, then enter DRAW with index 0; an UPDATE pass therefore takes exactly N_ENEMY cycles.
REQ-010 Enemies with cfg_en=0 SHALL keep position and direction in UPDATE and SHALL be skipped in DRAW and collision.
REQ-011 X motion, computed at 10-bit width: leftwards, x<=dx -> x=0, direction becomes rightwards; otherwise x=x-dx.
REQ-012 X motion, rightwards: x+dx+size>=SCREEN_W -> x=SCREEN_W-size, direction becomes leftwards; otherwise x=x+dx.
REQ-013 Y motion SHALL follow REQ-011/012 with dy, up/down and SCREEN_H.
REQ-014 Collision SHALL be evaluated in UPDATE on the enemy's new position: overlap iff px<=ex+size-1, ex<=px+PLAYER_SIZE-1, and the same on Y.
REQ-015 On the first collision, player_hit SHALL set and hit_id SHALL capture that index; both SHALL hold until reset or load_level. Within a pass the lowest index wins.
REQ-016 DRAW SHALL present one record per enabled enemy, ascending index; draw_valid and the record fields SHALL remain stable until a cycle with draw_valid&draw_ready.
REQ-017 After the last handshake, or immediately if no enemy is enabled, the FSM SHALL pulse step_done for one cycle and return to IDLE; draw_valid SHALL be 0 in that cycle.
REQ-018 Dropping play during UPDATE or DRAW SHALL NOT abort the pass.
REQ-019 load_level=1 in any state SHALL take priority over play and over the FSM.

Reset
REQ-020 On resetn=0 or load_level=1 at a clk edge, the following SHALL apply: enemy_x/enemy_y=cfg_x/cfg_y; directions=cfg_left/cfg_up; counter=0; state=IDLE; player_hit=0; hit_id=0; draw_valid=0; step_done=0; draw fields=0.
REQ-021 Reset SHALL take effect mid-UPDATE or mid-DRAW with no further handshakes or step_done.

Verification (RATE_DIV=4, N_ENEMY=2)
REQ-022 Bench SHALL cover: E0 x=10,y=10,dx=2,dy=1, right/down, play=1 -> after 4 cycles UPDATE; E0 becomes (12,11); step_done follows the second DRAW handshake.
REQ-023 Bench SHALL cover right-edge clamping: E0 x=155, size=3, dx=3, rightwards -> x=157, direction flips; next step x=154.
REQ-024 Bench SHALL cover left-edge clamping and collision priority: E1 x=2, dx=2, leftwards -> x=0, flips; player at (0,E1.y) overlapping E0 and E1 in the same pass -> player_hit=1, hit_id=0.
REQ-025 Bench SHALL cover draw backpressure: draw_ready=0 for 5 cycles -> draw_valid held and record stable; the counter does not run; exactly 2 records are accepted.
REQ-026 Bench SHALL cover interrupted passes and skipped enemies: load_level mid-DRAW -> next cycle draw_valid=0, positions equal cfg, player_hit=0; cfg_en=2'b00 -> step_done 1 cycle after UPDATE, no draw_valid.
